dsp_port_arbiter: RTL
=====================

# dsp_port_arbiter

Round-robin arbiter and issue sequencer that shares one DSP48A1 operand port between four requesters. It picks one requester per cycle and steers that requester's operand through a 4:1 `MUX` instance into a registered DSP operand. It also carries a requester-ID tag down a delay line matched to the DSP pipeline, so each result can be routed back to its owner. It sits between the requester front-ends and the DSP slice wrapper.

## Interface
- `WIDTH`, 18: operand width in bits.
- `PIPE_DEPTH`, 4: DSP latency in cycles, from `dsp_a` valid to result valid. Legal range 1..8.
- `MAX_BURST`, 8: maximum consecutive grants to one locked requester. Legal range 1..15.
- `CLK`  in  1: clock. All state changes on the rising edge.
- `RST_n`  in  1: reset, asynchronous and active-low.
- `ce`  in  1: clock enable. Low freezes all state and outputs, matching DSP CE.
- `req`  in  4: request per requester.
- `lock`  in  4: hold-grant request. Sampled only for the currently granted requester.
- `din0`..`din3`  in  WIDTH: requester operands.
- `gnt`  out  4: one-hot grant, combinational, same cycle as `req`.
- `dsp_a`  out  WIDTH: registered operand to DSP.
- `dsp_vld`  out  1: `dsp_a` holds a newly issued operand.
- `tag_vld`  out  1: DSP result at the current cycle belongs to `tag_id`.
- `tag_id`  out  2: owner of that result.

## Operation
- Handshake: a transfer occurs when `req[i] & gnt[i] & ce`.
  - At most one `gnt` bit is high.
  - `gnt` is zero when `ce` is low or `req` is zero.
- Round-robin: a 2-bit `last` register holds the last granted index.
  - Search order is `last+1`, `last+2`, `last+3`, `last` (mod 4).
  - After reset, `last` = 3, so requester 0 has top priority.
- FSM states:
  - IDLE: no transfer last cycle.
  - ISSUE: a normal grant occurred.
  - LOCKED: the granted requester asserted `lock` during its transfer.
- FSM transitions:
  - In LOCKED, the locked requester is granted whenever its `req` is high, regardless of round-robin.
  - Dropping `req` or `lock` returns to round-robin: state ISSUE if another requester transfers, else IDLE.
  - `burst_cnt` counts consecutive locked transfers. When it reaches `MAX_BURST`, the next cycle ignores `lock` and does a round-robin search that starts after the locked index. `burst_cnt` then clears.
- Datapath:
  - `sel` equals the encoded `gnt`, driven into the `MUX`.
  - `MUX` output is registered into `dsp_a` on a transfer. Otherwise `dsp_a` holds its value.
  - `dsp_vld` = registered transfer flag.
- Tag line: a `PIPE_DEPTH`-stage shift register of {valid, id}, fed from {`dsp_vld`, issued id}, advancing only when `ce` is high.
- Reset values: `gnt`=0, `dsp_a`=0, `dsp_vld`=0, `tag_vld`=0, `tag_id`=0, all tag stages 0, `last`=3, `burst_cnt`=0, state IDLE.
- Reset mid-operation: all in-flight tags are discarded, so no `tag_vld` appears for operands issued before reset.

## Timing
- `req` to `gnt`: 0 cycles (combinational).
- Transfer at edge N:
  - `dsp_a`/`dsp_vld` valid in cycle N+1.
  - `tag_vld`/`tag_id` valid in cycle N+1+`PIPE_DEPTH`.
- Sustained throughput: one issue per enabled cycle.
- `ce` low for k cycles delays every in-flight output by exactly k cycles. No tag is lost or duplicated.
- Simultaneous events:
  - `lock` and `MAX_BURST` reached in the same cycle: the forced rotation wins.
  - `req` dropped by the locked requester while others request: those others are granted in the same cycle.

## Structure
- Shared package `dsp_arb_pkg`:
  - FSM state enum (IDLE, ISSUE, LOCKED).
  - `N_REQ`=4 and `ID_W`=2.
  - Round-robin priority function (mask-and-find-first from `last+1`).
- One sub-module: `MUX` instantiated with `WIDTH`, `INPUTS`=4.
- Tag delay line is inline; no separate module.

## Test plan
- Reset and single requester:
  - Stimulus: `RST_n` low, release; then `req`=0001, `din0`=0x00A5 for 1 cycle.
  - Response: `gnt`=0001; `dsp_a`=0x00A5 and `dsp_vld`=1 next cycle; `tag_vld`=1, `tag_id`=0 at issue+1+`PIPE_DEPTH`.
- Fair rotation:
  - Stimulus: `req`=1111 held for 8 cycles.
  - Response: grant order 0,1,2,3,0,1,2,3; tags emerge in the same order.
- Burst limit:
  - Stimulus: `MAX_BURST`=8; `req`=0011, `lock`=0001 held.
  - Response: requester 0 gets 8 consecutive grants, then requester 1 gets 1, then requester 0 resumes locking.
- Stall:
  - Stimulus: issue ids 2,3; `ce` low 3 cycles mid-flight.
  - Response: `gnt`=0 while stalled; tags 2,3 appear exactly 3 cycles late, in order, once each.
- Reset mid-flight:
  - Stimulus: issue 3 operands; assert `RST_n` low asynchronously before any tag emerges.
  - Response: all outputs 0 immediately; no `tag_vld` after release until new issues.
- Priority after idle:
  - Stimulus: grant requester 2, idle 5 cycles, then `req`=0101.
  - Response: requester 0 granted first (search starts at 3).

Source files
------------

// File: rtl/dsp_arb_pkg.sv
// rtl/dsp_arb_pkg.sv - shared types and round-robin helpers for the DSP port arbiter
package dsp_arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_LOCKED
    } arb_state_e;

    // One-hot pick of the first requester found searching last+1, last+2, ... wrapping to last.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [ID_W-1:0]  last);
        logic [N_REQ-1:0] pick;
        logic [ID_W-1:0]  idx;
        pick = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = last + ID_W'(k);
            if (pick == '0 && req[idx]) begin
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [ID_W-1:0] onehot_enc(input logic [N_REQ-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                id = ID_W'(i);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/MUX.sv
// rtl/MUX.sv - parameterised N:1 operand multiplexer
module MUX #(
    parameter int  WIDTH  = 18,
    parameter int  INPUTS = 4,
    localparam int SEL_W  = $clog2(INPUTS)
) (
    input  logic [WIDTH-1:0] din_i [INPUTS],
    input  logic [SEL_W-1:0] sel_i,
    output logic [WIDTH-1:0] dout_o
);

    assign dout_o = din_i[sel_i];

endmodule

// File: rtl/dsp_port_arbiter.sv
// rtl/dsp_port_arbiter.sv - round-robin/locking arbiter sharing one DSP operand port, with result tag line
module dsp_port_arbiter
    import dsp_arb_pkg::*;
#(
    parameter int WIDTH      = 18,
    parameter int PIPE_DEPTH = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             ce,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] lock,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    output logic [N_REQ-1:0] gnt,
    output logic [WIDTH-1:0] dsp_a,
    output logic             dsp_vld,
    output logic             tag_vld,
    output logic [ID_W-1:0]  tag_id
);

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [3:0]       burst_q, burst_d;
    logic [WIDTH-1:0] dsp_a_q;
    logic             dsp_vld_q;
    logic [ID_W-1:0]  id_q;
    logic             tv_q  [PIPE_DEPTH];
    logic [ID_W-1:0]  tid_q [PIPE_DEPTH];

    logic             force_rr;
    logic             hold_lock;
    logic [N_REQ-1:0] gnt_c;
    logic [ID_W-1:0]  gid;
    logic             xfer;
    logic [WIDTH-1:0] din_arr [N_REQ];
    logic [WIDTH-1:0] mux_out;

    assign din_arr[0] = din0;
    assign din_arr[1] = din1;
    assign din_arr[2] = din2;
    assign din_arr[3] = din3;

    always_comb begin
        // A full burst overrides lock for one search, starting just after the locked index.
        force_rr  = (state_q == ST_LOCKED) && (burst_q >= BURST_LIM);
        hold_lock = (state_q == ST_LOCKED) && !force_rr && req[last_q];
        gnt_c     = '0;
        if (ce && RST_n && (req != '0)) begin
            if (hold_lock) begin
                gnt_c[last_q] = 1'b1;
            end else begin
                gnt_c = rr_pick(req, last_q);
            end
        end
        gid  = onehot_enc(gnt_c);
        xfer = |gnt_c;

        state_d = state_q;
        last_d  = last_q;
        burst_d = burst_q;
        if (ce) begin
            if (xfer) begin
                last_d = gid;
                if (lock[gid] && !force_rr) begin
                    state_d = ST_LOCKED;
                    burst_d = (state_q == ST_LOCKED && gid == last_q) ? burst_q + 4'd1 : 4'd1;
                end else begin
                    state_d = ST_ISSUE;
                    burst_d = 4'd0;
                end
            end else begin
                state_d = ST_IDLE;
                burst_d = 4'd0;
            end
        end
    end

    MUX #(
        .WIDTH  (WIDTH),
        .INPUTS (N_REQ)
    ) u_mux (
        .din_i  (din_arr),
        .sel_i  (gid),
        .dout_o (mux_out)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= ST_IDLE;
            last_q    <= ID_W'(N_REQ - 1);
            burst_q   <= 4'd0;
            dsp_a_q   <= '0;
            dsp_vld_q <= 1'b0;
            id_q      <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                tv_q[i]  <= 1'b0;
                tid_q[i] <= '0;
            end
        end else if (ce) begin
            state_q   <= state_d;
            last_q    <= last_d;
            burst_q   <= burst_d;
            dsp_vld_q <= xfer;
            if (xfer) begin
                dsp_a_q <= mux_out;
                id_q    <= gid;
            end
            for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
                tv_q[i]  <= tv_q[i-1];
                tid_q[i] <= tid_q[i-1];
            end
            tv_q[0]  <= dsp_vld_q;
            tid_q[0] <= id_q;
        end
    end

    assign gnt     = gnt_c;
    assign dsp_a   = dsp_a_q;
    assign dsp_vld = dsp_vld_q;
    assign tag_vld = tv_q[PIPE_DEPTH-1];
    assign tag_id  = tid_q[PIPE_DEPTH-1];

endmodule
